// File: rtl/irq_defs.sv
// Shared definitions for the interrupt controller: sizes, vector base and FSM states.
package irq_defs;

  localparam int unsigned N_IRQ_DEF = 4;
  localparam int unsigned ID_W      = 2;
  localparam int unsigned PC_W      = 10;
  localparam logic [PC_W-1:0] VEC_BASE_DEF = 10'd1008;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVICE = 2'd1,
    ST_RETURN  = 2'd2
  } state_t;

  // Vector table entries are 4 words apart.
  function automatic logic [PC_W-1:0] vec_addr(input logic [PC_W-1:0] base,
                                               input logic [ID_W-1:0] id);
    vec_addr = PC_W'(base + PC_W'({id, 2'b00}));
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module irq_prio_enc
  import irq_defs::*;
(
  input  logic [3:0]      req,
  output logic [ID_W-1:0] idx,
  output logic            valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b1;
    if (req[0])      idx = 2'd0;
    else if (req[1]) idx = 2'd1;
    else if (req[2]) idx = 2'd2;
    else if (req[3]) idx = 2'd3;
    else             valid = 1'b0;
  end

endmodule

// File: rtl/irq_ctrl.sv
// Vectored interrupt controller with return-address stack handshake.
// Define IRQ_CTRL_EDGE_EN for rising-edge request capture (default: level).
module irq_ctrl
  import irq_defs::*;
#(
  parameter logic [PC_W-1:0] VEC_BASE = VEC_BASE_DEF,
  parameter int unsigned     N_IRQ    = N_IRQ_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             ie,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wd,
  input  logic [PC_W-1:0]  pc_next,
  input  logic             reti,
  input  logic [PC_W-1:0]  pop_data,
  output logic             push,
  output logic [PC_W-1:0]  push_data,
  output logic             pop,
  output logic             pc_sel,
  output logic [PC_W-1:0]  pc_vector,
  output logic             stall,
  output logic             in_service,
  output logic [ID_W-1:0]  cur_id,
  output logic [N_IRQ-1:0] pending_o
);

  state_t           state;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] set_vec;
  logic [N_IRQ-1:0] clr_vec;
  logic [ID_W-1:0]  win_idx;
  logic             win_vld;
  logic             take;

  irq_prio_enc u_prio (
    .req   (pending & mask),
    .idx   (win_idx),
    .valid (win_vld)
  );

`ifdef IRQ_CTRL_EDGE_EN
  logic [N_IRQ-1:0] irq_hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_hist <= '0;
    else       irq_hist <= irq;
  end

  assign set_vec = irq & ~irq_hist;
`else
  assign set_vec = irq;
`endif

  assign take    = !reset && (state == ST_IDLE) && ie && win_vld;
  assign clr_vec = take ? N_IRQ'(N_IRQ'(1) << win_idx) : '0;

  // Clear of the winning bit takes precedence over a same-edge set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      pending <= '0;
      mask    <= '0;
      cur_id  <= '0;
    end else begin
      pending <= (pending | set_vec) & ~clr_vec;
      if (mask_we) mask <= mask_wd;
      case (state)
        ST_IDLE: begin
          if (take) begin
            cur_id <= win_idx;
            state  <= ST_SERVICE;
          end
        end
        ST_SERVICE: if (reti) state <= ST_RETURN;
        ST_RETURN:  state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Same-cycle CPU control: vector on take, stack pop on reti, restore in RETURN.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    pop       = 1'b0;
    stall     = 1'b0;
    pc_sel    = 1'b0;
    pc_vector = '0;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            push      = 1'b1;
            push_data = pc_next;
            pc_sel    = 1'b1;
            pc_vector = vec_addr(VEC_BASE, win_idx);
          end
        end
        ST_SERVICE: begin
          if (reti) begin
            pop   = 1'b1;
            stall = 1'b1;
          end
        end
        ST_RETURN: begin
          pc_sel    = 1'b1;
          pc_vector = pop_data;
        end
        default: ;
      endcase
    end
  end

  assign in_service = (state == ST_SERVICE) || (state == ST_RETURN);
  assign pending_o  = pending;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       ie;
  logic       mask_we;
  logic [3:0] mask_wd;
  logic [9:0] pc_next;
  logic       reti;
  logic [9:0] pop_data;
  logic       push;
  logic [9:0] push_data;
  logic       pop;
  logic       pc_sel;
  logic [9:0] pc_vector;
  logic       stall;
  logic       in_service;
  logic [1:0] cur_id;
  logic [3:0] pending_o;

  int checks   = 0;
  int failures = 0;

  irq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .ie         (ie),
    .mask_we    (mask_we),
    .mask_wd    (mask_wd),
    .pc_next    (pc_next),
    .reti       (reti),
    .pop_data   (pop_data),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .pc_sel     (pc_sel),
    .pc_vector  (pc_vector),
    .stall      (stall),
    .in_service (in_service),
    .cur_id     (cur_id),
    .pending_o  (pending_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; irq = 4'hF; ie = 1'b1; mask_we = 1'b0; mask_wd = 4'h0;
    pc_next = '0; reti = 1'b0; pop_data = '0;
    tick(); tick();
    check("rst_push",    32'(push),       0);
    check("rst_pc_sel",  32'(pc_sel),     0);
    check("rst_pending", 32'(pending_o),  0);
    check("rst_insvc",   32'(in_service), 0);
    irq = 4'h0; ie = 1'b0;
    @(negedge clk); reset = 1'b0;
    tick();

    // Take and return of source 2
    mask_we = 1'b1; mask_wd = 4'hF; tick(); mask_we = 1'b0;
    ie = 1'b1; irq = 4'b0100; pc_next = 10'd37;
    tick(); irq = 4'b0000; settle();
    check("take_push",      32'(push),      1);
    check("take_push_data", 32'(push_data), 37);
    check("take_pc_sel",    32'(pc_sel),    1);
    check("take_vector",    32'(pc_vector), 1016);
    tick();
    check("svc_cur_id",  32'(cur_id),     2);
    check("svc_insvc",   32'(in_service), 1);
    check("svc_pending", 32'(pending_o),  0);
    reti = 1'b1; settle();
    check("reti_pop",   32'(pop),   1);
    check("reti_stall", 32'(stall), 1);
    tick(); pop_data = 10'd37; settle();
    check("ret_pc_sel", 32'(pc_sel),    1);
    check("ret_vector", 32'(pc_vector), 37);
    check("ret_no_pop", 32'(pop),       0);
    reti = 1'b0;
    tick();
    check("idle_insvc",  32'(in_service), 0);
    check("idle_vector", 32'(pc_vector),  0);

    // Priority: source 1 beats source 3; source 3 waits for return
    irq = 4'b1010; tick(); irq = 4'b0000; settle();
    check("prio_vector", 32'(pc_vector), 1012);
    tick();
    check("prio_cur_id",   32'(cur_id),    1);
    check("prio_no_take",  32'(pc_sel),    0);
    check("prio_pending3", 32'(pending_o), 4'b1000);
    reti = 1'b1; tick(); reti = 1'b0; pop_data = 10'd99; settle();
    check("prio_ret_vec", 32'(pc_vector), 99);
    tick();
    check("prio_take3", 32'(pc_vector), 1020);
    tick();
    check("prio_cur3", 32'(cur_id), 3);
    reti = 1'b1; tick(); reti = 1'b0; tick();

    // Masked source stays pending; mask write during the cycle uses old mask
    mask_we = 1'b1; mask_wd = 4'b1110; tick(); mask_we = 1'b0;
    irq = 4'b0001; tick(); irq = 4'b0000; settle();
    check("mask_no_take", 32'(pc_sel),    0);
    check("mask_pending", 32'(pending_o), 4'b0001);
    mask_we = 1'b1; mask_wd = 4'hF; settle();
    check("mask_old_used", 32'(pc_sel), 0);
    tick(); mask_we = 1'b0; settle();
    check("mask_new_vec", 32'(pc_vector), 1008);
    tick();
    // Request during SERVICE stays pending, then reset abandons the ISR
    irq = 4'b0010; tick(); irq = 4'b0000; settle();
    check("svc_hold_pend", 32'(pending_o), 4'b0010);
    check("svc_hold_take", 32'(pc_sel),    0);
    reset = 1'b1; settle();
    check("rst_mid_insvc",   32'(in_service), 0);
    check("rst_mid_pending", 32'(pending_o),  0);
    tick(); @(negedge clk); reset = 1'b0;
    reti = 1'b1; settle();
    check("rst_reti_pop",   32'(pop),   0);
    check("rst_reti_stall", 32'(stall), 0);
    reti = 1'b0;

    // ie=0 blocks takes and keeps pending; winner clear beats same-edge set
    mask_we = 1'b1; mask_wd = 4'hF; tick(); mask_we = 1'b0;
    ie = 1'b0; irq = 4'hF; tick(); irq = 4'h0; settle();
    check("ie0_no_take", 32'(pc_sel),    0);
    tick();
    check("ie0_pending", 32'(pending_o), 4'hF);
    check("ie0_still",   32'(push),      0);
    ie = 1'b1; irq = 4'b0001; settle();
    check("ie1_take_vec", 32'(pc_vector), 1008);
    tick(); irq = 4'b0000; settle();
    check("clr_wins_pend", 32'(pending_o), 4'b1110);
    check("clr_wins_id",   32'(cur_id),    0);
    reti = 1'b1; tick(); reti = 1'b0; tick(); tick(); tick();

`ifdef IRQ_CTRL_EDGE_EN
    // Held line across RETI yields exactly one take
    reset = 1'b1; tick(); @(negedge clk); reset = 1'b0;
    mask_we = 1'b1; mask_wd = 4'hF; tick(); mask_we = 1'b0;
    ie = 1'b1; irq = 4'b0001; tick();
    check("edge_take", 32'(push), 1);
    tick();
    reti = 1'b1; tick(); reti = 1'b0; tick();
    check("edge_no_retake",  32'(push),      0);
    check("edge_no_pending", 32'(pending_o), 0);
    irq = 4'b0000; tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter VEC_BASE, default 10'd1008, base address of the interrupt vector table.
REQ-002 Parameter N_IRQ, default 4, number of interrupt sources (fixed at 4 in this revision).
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 irq  in  4  interrupt request lines; bit 0 has highest priority.
REQ-006 ie  in  1  global interrupt enable from the CPU.
REQ-007 mask_we / mask_wd  in  1 / 4  mask register write strobe and data; 1 = source enabled.
REQ-008 pc_next  in  10  CPU's next-sequential PC, which becomes the return address.
REQ-009 reti  in  1  decoded return-from-interrupt instruction.
REQ-010 pop_data  in  10  stack read data, valid the cycle after pop.
REQ-011 push / push_data  out  1 / 10  stack push strobe and return address.
REQ-012 pop  out  1  stack pop strobe.
REQ-013 pc_sel / pc_vector  out  1 / 10  PC override select and override value.
REQ-014 stall  out  1  CPU shall not commit PC or register writes this cycle.
REQ-015 in_service / cur_id / pending_o  out  1 / 2 / 4  status: ISR active, active source, pending bits.

Function
REQ-016 States: IDLE, SERVICE, RETURN.
REQ-017 pending[i] sets on any cycle irq[i]=1 (level mode); pending[i] persists until taken.
REQ-018 Take condition: state IDLE, ie=1, and (pending & mask) != 0; winner is the lowest set index.
REQ-019 Take cycle (combinational, same cycle): push=1, push_data=pc_next, pc_sel=1, pc_vector=VEC_BASE+4*winner.
REQ-020 At the take edge: pending[winner] cleared, cur_id<=winner, state<=SERVICE.
REQ-021 SERVICE with reti=1: pop=1 and stall=1 that cycle; state<=RETURN.
REQ-022 RETURN: pc_sel=1, pc_vector=pop_data, reti ignored; state<=IDLE at the next edge.
REQ-023 No take occurs in SERVICE or RETURN; requests arriving then stay pending.
REQ-024 reti in IDLE or RETURN is ignored: no pop, no stall.
REQ-025 Same-edge set and clear of the winner bit: clear wins; sets on other bits are kept.
REQ-026 mask_we in a take cycle: the take uses the old mask; the new mask applies from the next cycle.
REQ-027 ie=0 in IDLE: no take; pending bits are retained.
REQ-028 Outputs not explicitly driven are 0; pc_vector is 0 when pc_sel=0.
REQ-029 in_service=1 in SERVICE and RETURN; pending_o=pending.

Reset
REQ-030 reset asserted: state=IDLE, pending=0, mask=4'b0000, cur_id=0, edge history=0.
REQ-031 All outputs are 0 during reset.
REQ-032 Reset mid-SERVICE or mid-RETURN abandons the ISR; no pop is issued.

Configuration
REQ-033 With IRQ_CTRL_EDGE_EN defined: pending[i] sets only on a 0->1 transition of irq[i], using a registered history bit per line.
REQ-034 IRQ_CTRL_EDGE_EN undefined: level mode as REQ-017; no history registers are present.

Structure
REQ-035 Shared package/header irq_defs holds the state encodings, N_IRQ and the VEC_BASE default.
REQ-036 The priority selection is sub-module irq_prio_enc (4-bit in, 2-bit index plus valid out).

Verification
REQ-037 Take and return sequence:
- Stimulus: mask=4'hF, ie=1, irq=4'b0100, pc_next=10'd37.
- Same cycle: push=1, push_data=37, pc_sel=1, pc_vector=1016.
- Next cycle: cur_id=2.
REQ-038 Return restores PC: in SERVICE, reti=1 gives pop=1 and stall=1; next cycle, with pop_data=37, pc_vector=37 and pc_sel=1; then IDLE.
REQ-039 Priority: irq=4'b1010 with mask=4'hF gives pc_vector=1012 (source 1); source 3 is taken only after RETI.
REQ-040 Masking and enable:
- mask=4'b1110 with irq[0]=1: no take, pending_o[0]=1.
- Writing mask=4'hF: take at vector 1008.
- ie=0: no take for any source.
REQ-041 Reset mid-SERVICE returns to IDLE with pending_o=0; a following reti produces no pop.
REQ-042 With IRQ_CTRL_EDGE_EN defined, irq[0] held high across RETI produces exactly one take.
